// File: rtl/ccip_c1tx_arbiter_if.sv
// Requester-side and C1Tx-side signals of the C1Tx write arbiter.
// The slave modport is the arbiter view; master is the AFU/downstream view.
interface ccip_c1tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = 64,
  parameter int DATA_W  = 512
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_len;
  logic [HDR_W*NUM_REQ-1:0]  req_hdr;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_err;
  logic                      C1TxAlmFull;
  logic                      C1TxWrValid;
  logic                      C1TxSop;
  logic [1:0]                C1TxLen;
  logic [1:0]                C1TxClNum;
  logic [HDR_W-1:0]          C1TxHdr;
  logic [DATA_W-1:0]         C1TxData;
  logic                      busy;

  modport slave (
    input  req_valid, req_len, req_hdr, req_data, C1TxAlmFull,
    output req_ready, req_err, C1TxWrValid, C1TxSop, C1TxLen, C1TxClNum,
           C1TxHdr, C1TxData, busy
  );

  modport master (
    output req_valid, req_len, req_hdr, req_data, C1TxAlmFull,
    input  req_ready, req_err, C1TxWrValid, C1TxSop, C1TxLen, C1TxClNum,
           C1TxHdr, C1TxData, busy
  );
endinterface

// File: rtl/ccip_c1tx_arbiter.sv
// Round-robin arbiter sharing the CCI-P C1Tx write channel between NUM_REQ
// requesters; multi-cacheline writes are granted as atomic bursts.
module ccip_c1tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = 64,
  parameter int DATA_W  = 512
) (
  input logic                clk,
  input logic                SoftReset_n,
  ccip_c1tx_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] LEN_1CL = 2'b00;
  localparam logic [1:0] LEN_2CL = 2'b01;
  localparam logic [1:0] LEN_3CL = 2'b10;
  localparam logic [1:0] LEN_4CL = 2'b11;

  typedef enum logic {IDLE, BURST} arbState;

  arbState          state;
  logic [PTR_W-1:0] rrPtr;
  logic [PTR_W-1:0] grantIdx;
  logic [1:0]       beatCnt;
  logic [1:0]       burstLen;

  logic               found;
  logic [PTR_W-1:0]   winIdx;
  logic [1:0]         winLen;
  logic               idleGrant;
  logic               issue;
  logic               issueSop;
  logic [PTR_W-1:0]   issueIdx;
  logic [1:0]         issueLen;
  logic [1:0]         issueClNum;
  logic [HDR_W-1:0]   issueHdr;
  logic [DATA_W-1:0]  issueData;
  logic               lastBeat;
  logic [NUM_REQ-1:0] readyVec;
  logic [NUM_REQ-1:0] errVec;

  function automatic logic [PTR_W-1:0] wrapIdx(input int v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  function automatic logic [PTR_W-1:0] nextIdx(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  // First valid requester at or after rrPtr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[wrapIdx(int'(rrPtr) + k)]) begin
        found  = 1'b1;
        winIdx = wrapIdx(int'(rrPtr) + k);
      end
    end
  end

  assign winLen    = bus.req_len[2*winIdx +: 2];
  assign idleGrant = (state == IDLE) && !bus.C1TxAlmFull && found;
  assign lastBeat  = (burstLen == LEN_4CL) ? (beatCnt == 2'd3) : (beatCnt == 2'd1);

  // Grant decision; ready is held low while reset is asserted.
  always_comb begin
    readyVec   = '0;
    errVec     = '0;
    issue      = 1'b0;
    issueSop   = 1'b0;
    issueIdx   = winIdx;
    issueLen   = winLen;
    issueClNum = 2'd0;
    if (SoftReset_n) begin
      case (state)
        IDLE: begin
          if (idleGrant) begin
            readyVec[winIdx] = 1'b1;
            if (winLen == LEN_3CL) begin
              errVec[winIdx] = 1'b1;
            end else begin
              issue    = 1'b1;
              issueSop = 1'b1;
            end
          end
        end
        BURST: begin
          if (!bus.C1TxAlmFull && bus.req_valid[grantIdx]) begin
            readyVec[grantIdx] = 1'b1;
            issue              = 1'b1;
            issueIdx           = grantIdx;
            issueLen           = burstLen;
            issueClNum         = beatCnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign issueHdr      = bus.req_hdr[issueIdx*HDR_W +: HDR_W];
  assign issueData     = bus.req_data[issueIdx*DATA_W +: DATA_W];
  assign bus.req_ready = readyVec;
  assign bus.req_err   = errVec;

  // Burst FSM and the registered C1Tx beat; payload only loads on an issued beat.
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state           <= IDLE;
      rrPtr           <= '0;
      grantIdx        <= '0;
      beatCnt         <= 2'd0;
      burstLen        <= LEN_1CL;
      bus.busy        <= 1'b0;
      bus.C1TxWrValid <= 1'b0;
      bus.C1TxSop     <= 1'b0;
      bus.C1TxLen     <= 2'd0;
      bus.C1TxClNum   <= 2'd0;
      bus.C1TxHdr     <= '0;
      bus.C1TxData    <= '0;
    end else begin
      bus.C1TxWrValid <= issue;
      bus.C1TxSop     <= issue && issueSop;
      if (issue) begin
        bus.C1TxLen   <= issueLen;
        bus.C1TxClNum <= issueClNum;
        bus.C1TxHdr   <= issueHdr;
        bus.C1TxData  <= issueData;
      end
      case (state)
        IDLE: begin
          if (idleGrant) begin
            if (winLen == LEN_1CL || winLen == LEN_3CL) begin
              rrPtr <= nextIdx(winIdx);
            end else begin
              grantIdx <= winIdx;
              burstLen <= winLen;
              beatCnt  <= 2'd1;
              bus.busy <= 1'b1;
              state    <= BURST;
            end
          end
        end
        BURST: begin
          if (issue) begin
            if (lastBeat) begin
              rrPtr    <= nextIdx(grantIdx);
              beatCnt  <= 2'd0;
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              beatCnt <= beatCnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants are exclusive, and a dropped 3CL request is always consumed.
  assert property (@(posedge clk) disable iff (!SoftReset_n) $onehot0(bus.req_ready));
  assert property (@(posedge clk) disable iff (!SoftReset_n) (bus.req_err & ~bus.req_ready) == '0);

endmodule
